// File: rtl/skid_buffer.sv
// Two-entry elastic pipeline register with valid/ready on both sides.
// in_ready depends only on the state register, so out_ready never reaches it combinationally.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  logic acc;
  logic pop;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Drop everything; a pop this cycle is still treated as consumed downstream.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d     = StBusy;
            main_data_d = in_data;
          end
        end
        StBusy: begin
          if (acc && pop) begin
            main_data_d = in_data;
          end else if (acc) begin
            state_d     = StFull;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d     = StBusy;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    unique case (state_q)
      StEmpty: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
      StBusy: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
      end
      StFull: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

  assign out_data = main_data_q;

endmodule
